// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 keyboard frame receiver and scan-code decoder.
// Synchronizes the raw PS/2 pins and deframes 11-bit frames on falling
// clock edges. Folds E0/F0 prefixes into single-cycle key events and keeps a
// held-key bitmap for the piano keys plus up/down/enter.
module ps2_scan_receiver #(
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       scan_ext,
  output logic       scan_break,
  output logic       frame_err,
  output logic [9:0] key_held
);

  // Counter wide enough to hold TIMEOUT_CYCLES itself.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Last count value before the abort fires.
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Map a decoded byte to its bitmap slot. Extended and plain codes live in
  // disjoint tables, so E0 1C never touches the A key and plain 75 never
  // touches the up key.
  function automatic logic [9:0] key_mask(input logic [7:0] code,
                                          input logic       ext);
    key_mask = '0;
    if (!ext) begin
      case (code)
        8'h1C:   key_mask = 10'h001;  // A
        8'h1B:   key_mask = 10'h002;  // S
        8'h23:   key_mask = 10'h004;  // D
        8'h2B:   key_mask = 10'h008;  // F
        8'h34:   key_mask = 10'h010;  // G
        8'h33:   key_mask = 10'h020;  // H
        8'h3B:   key_mask = 10'h040;  // J
        8'h5A:   key_mask = 10'h200;  // enter
        default: key_mask = '0;
      endcase
    end else begin
      case (code)
        8'h75:   key_mask = 10'h080;  // up
        8'h72:   key_mask = 10'h100;  // down
        default: key_mask = '0;
      endcase
    end
  endfunction

  // Synchronizer and edge-detect state.
  logic clk_s1, clk_s2, clk_s3;
  logic data_s1, data_s2;
  logic fall;

  // Frame FSM state and datapath.
  state_t          state, state_nxt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            par_bit;
  logic            par_ok;
  logic [CW-1:0]   tmo_cnt;
  logic            tmo_hit;
  logic            byte_ok;
  logic            err;

  // Prefix flags waiting for the final byte of an event.
  logic            pend_ext;
  logic            pend_brk;
  logic [9:0]      mask;

  // Two-flop synchronizers plus one extra clock stage for the edge compare.
  // They reset to 1 so an idle-high bus never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Falling edge of the synchronized PS/2 clock; data_s2 is aligned with it.
  assign fall = clk_s3 & ~clk_s2;

  // Odd parity over the 8 data bits and the parity bit.
  assign par_ok = ^{shift, par_bit};

  // Abort only when no edge arrives on the cycle the count would reach the
  // limit; a coincident edge keeps the frame alive.
  assign tmo_hit = (state != S_IDLE) && !fall && (tmo_cnt == TMO_LAST);

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Frame FSM next state plus byte-accept / error strobes.
  always_comb begin
    state_nxt = state;
    byte_ok   = 1'b0;
    err       = 1'b0;
    if (tmo_hit) begin
      state_nxt = S_IDLE;
      err       = 1'b1;
    end else if (fall) begin
      case (state)
        S_IDLE: begin
          if (!data_s2) state_nxt = S_DATA;
          else          err       = 1'b1;  // start bit must be 0
        end
        S_DATA: begin
          if (bit_cnt == 3'd7) state_nxt = S_PARITY;
        end
        S_PARITY: state_nxt = S_STOP;
        S_STOP: begin
          state_nxt = S_IDLE;
          if (data_s2 && par_ok) byte_ok = 1'b1;
          else                   err     = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Data shift register, bit counter and parity capture.
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else if (fall && !tmo_hit) begin
      case (state)
        S_IDLE: bit_cnt <= '0;
        S_DATA: begin
          shift   <= {data_s2, shift[7:1]};  // LSB arrives first
          bit_cnt <= bit_cnt + 3'd1;
        end
        S_PARITY: par_bit <= data_s2;
        default: ;
      endcase
    end
  end

  // Inter-edge timeout counter: cleared by edges, held at 0 while idle.
  always_ff @(posedge clk) begin
    if (!sys_rst_n)              tmo_cnt <= '0;
    else if (fall)               tmo_cnt <= '0;
    else if (state == S_IDLE)    tmo_cnt <= '0;
    else if (tmo_hit)            tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign mask = key_mask(shift, pend_ext);

  // Byte decoder: prefix tracking, event outputs and held-key bitmap.
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      scan_valid <= 1'b0;
      scan_code  <= '0;
      scan_ext   <= 1'b0;
      scan_break <= 1'b0;
      frame_err  <= 1'b0;
      key_held   <= '0;
      pend_ext   <= 1'b0;
      pend_brk   <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= err;
      if (err) begin
        // A broken frame may have been part of a prefixed sequence.
        pend_ext <= 1'b0;
        pend_brk <= 1'b0;
      end else if (byte_ok) begin
        if (shift == 8'hE0) begin
          pend_ext <= 1'b1;
        end else if (shift == 8'hF0) begin
          pend_brk <= 1'b1;
        end else begin
          scan_valid <= 1'b1;
          scan_code  <= shift;
          scan_ext   <= pend_ext;
          scan_break <= pend_brk;
          pend_ext   <= 1'b0;
          pend_brk   <= 1'b0;
          // Typematic repeats simply set an already-set bit again.
          if (pend_brk) key_held <= key_held & ~mask;
          else          key_held <= key_held | mask;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: make/break/extended events, parity
// error, inter-edge timeout with prefix clearing, and reset mid-frame.
module tb_ps2_scan_receiver;

  logic       clk;
  logic       sys_rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       scan_ext;
  logic       scan_break;
  logic       frame_err;
  logic [9:0] key_held;

  int errors = 0;
  int checks = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;
  int v0, e0;

  ps2_scan_receiver #(.TIMEOUT_CYCLES(1000)) dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .scan_ext   (scan_ext),
    .scan_break (scan_break),
    .frame_err  (frame_err),
    .key_held   (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (scan_valid) n_valid = n_valid + 1;
    if (frame_err) n_err = n_err + 1;
    if (scan_valid && frame_err) n_both = n_both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One PS/2 bit: data set up mid-high, clock low 20 cycles, 40-cycle period.
  task automatic ps2_bit(input logic d);
    @(negedge clk);
    ps2_data = d;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (9) @(negedge clk);
  endtask

  // Full frame: start, 8 data LSB first, parity (good = odd total), stop.
  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic par;
    par = (~^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    repeat (10) @(negedge clk);
  endtask

  task automatic mark;
    v0 = n_valid;
    e0 = n_err;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    repeat (5) @(negedge clk);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset state
    chk("rst_valid", 32'(scan_valid), 32'h0);
    chk("rst_code", 32'(scan_code), 32'h00);
    chk("rst_ext", 32'(scan_ext), 32'h0);
    chk("rst_break", 32'(scan_break), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    chk("rst_held", 32'(key_held), 32'h000);
    chk("rst_pulses", 32'(n_valid + n_err), 32'h0);

    // Make 1C
    mark();
    send_frame(8'h1C, 1'b0);
    chk("make_pulses", 32'(n_valid - v0), 32'h1);
    chk("make_code", 32'(scan_code), 32'h1C);
    chk("make_ext", 32'(scan_ext), 32'h0);
    chk("make_break", 32'(scan_break), 32'h0);
    chk("make_held", 32'(key_held), 32'h001);

    // Break: F0 alone gives no event, then 1C releases
    mark();
    send_frame(8'hF0, 1'b0);
    chk("f0_no_event", 32'(n_valid - v0), 32'h0);
    send_frame(8'h1C, 1'b0);
    chk("brk_pulses", 32'(n_valid - v0), 32'h1);
    chk("brk_code", 32'(scan_code), 32'h1C);
    chk("brk_break", 32'(scan_break), 32'h1);
    chk("brk_held", 32'(key_held), 32'h000);

    // Extended make E0 75
    mark();
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    chk("ext_pulses", 32'(n_valid - v0), 32'h1);
    chk("ext_code", 32'(scan_code), 32'h75);
    chk("ext_ext", 32'(scan_ext), 32'h1);
    chk("ext_break", 32'(scan_break), 32'h0);
    chk("ext_held", 32'(key_held), 32'h080);

    // Typematic repeat of E0 75
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    chk("rep_pulses", 32'(n_valid - v0), 32'h2);
    chk("rep_held", 32'(key_held), 32'h080);

    // Extended break E0 F0 75
    mark();
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    chk("extbrk_pulses", 32'(n_valid - v0), 32'h1);
    chk("extbrk_flags", 32'({scan_ext, scan_break}), 32'h3);
    chk("extbrk_held", 32'(key_held), 32'h000);

    // Plain 75 is not the up key
    mark();
    send_frame(8'h75, 1'b0);
    chk("plain75_pulses", 32'(n_valid - v0), 32'h1);
    chk("plain75_ext", 32'(scan_ext), 32'h0);
    chk("plain75_held", 32'(key_held), 32'h000);

    // Parity error on 1C, then good 1B
    mark();
    send_frame(8'h1C, 1'b1);
    chk("par_err_pulses", 32'(n_err - e0), 32'h1);
    chk("par_no_valid", 32'(n_valid - v0), 32'h0);
    chk("par_held", 32'(key_held), 32'h000);
    send_frame(8'h1B, 1'b0);
    chk("s_code", 32'(scan_code), 32'h1B);
    chk("s_held", 32'(key_held), 32'h002);

    // Timeout: F0 accepted, then a frame stalls after 4 data bits
    send_frame(8'hF0, 1'b0);
    mark();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    // Pin falls now; the FSM sees the edge 3 clocks later and the abort
    // lands 1000 clocks after that.
    for (int k = 1; k <= 1002; k++) begin
      @(negedge clk);
      if (k == 20) ps2_clk = 1'b1;
    end
    chk("tmo_before", 32'(frame_err), 32'h0);
    @(negedge clk);
    chk("tmo_at", 32'(frame_err), 32'h1);
    @(negedge clk);
    chk("tmo_after", 32'(frame_err), 32'h0);
    chk("tmo_err_pulses", 32'(n_err - e0), 32'h1);
    chk("tmo_no_valid", 32'(n_valid - v0), 32'h0);
    repeat (20) @(negedge clk);
    mark();
    send_frame(8'h1C, 1'b0);
    chk("post_tmo_pulses", 32'(n_valid - v0), 32'h1);
    chk("post_tmo_break", 32'(scan_break), 32'h0);
    chk("post_tmo_held", 32'(key_held), 32'h003);

    // Reset mid-frame: start + 3 data bits, then a 1-cycle reset
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk);
    sys_rst_n = 1'b0;
    @(negedge clk);
    sys_rst_n = 1'b1;
    mark();
    ps2_data = 1'b1;
    repeat (1500) @(negedge clk);
    chk("rstmid_quiet", 32'((n_valid - v0) + (n_err - e0)), 32'h0);
    chk("rstmid_held", 32'(key_held), 32'h000);
    send_frame(8'h5A, 1'b0);
    chk("enter_pulses", 32'(n_valid - v0), 32'h1);
    chk("enter_errs", 32'(n_err - e0), 32'h0);
    chk("enter_code", 32'(scan_code), 32'h5A);
    chk("enter_held", 32'(key_held), 32'h200);

    chk("exclusive", 32'(n_both), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
